// File: rtl/vec_pkg.sv
// Shared defaults and width helpers for the pipelined dot-product block.
package vec_pkg;

    localparam int unsigned DEF_BIT_WIDTH  = 4;
    localparam int unsigned DEF_VEC_SIZE   = 64;
    localparam int unsigned DEF_MAX_CHUNKS = 16;

    // Result width: full product, tree growth, and headroom for MAX_CHUNKS beats.
    function automatic int unsigned res_width(int unsigned bw, int unsigned vs,
                                              int unsigned mc);
        return 2 * bw + $clog2(vs) + $clog2(mc);
    endfunction

    // Width of adder-tree level 'level' given the width entering level 0.
    function automatic int unsigned tree_width(int unsigned in_width, int unsigned level);
        return in_width + level;
    endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Registered binary reduction tree: one adder level per stage, all stages share
// one enable. Operands are treated as two's complement and grow by one bit per level.
module adder_tree_pipe
    import vec_pkg::*;
#(
    parameter int unsigned N         = 64,
    parameter int unsigned IN_WIDTH  = 9,
    parameter int unsigned TAG_WIDTH = 1,
    localparam int unsigned LEVELS   = $clog2(N),
    localparam int unsigned OUT_WIDTH = IN_WIDTH + LEVELS
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic [N*IN_WIDTH-1:0]   i_data,
    input  logic [TAG_WIDTH-1:0]    i_tag,
    output logic                    o_valid,
    output logic [OUT_WIDTH-1:0]    o_data,
    output logic [TAG_WIDTH-1:0]    o_tag
);

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int W   = int'(tree_width(IN_WIDTH, l));
        localparam int CNT = int'(N >> l);

        logic [CNT*W-1:0]     data;
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;

        if (l == 0) begin : g_in
            assign data  = i_data;
            assign valid = i_valid;
            assign tag   = i_tag;
        end else begin : g_reg
            localparam int PW = W - 1;

            logic [2*CNT*PW-1:0] prev;
            logic [CNT*W-1:0]    sum_d;

            assign prev = g_lvl[l-1].data;

            // Pairwise sign-extended sums of the previous level.
            always_comb begin
                sum_d = '0;
                for (int k = 0; k < CNT; k++) begin
                    sum_d[k*W +: W] =
                        {prev[(2*k)*PW + PW - 1], prev[(2*k)*PW +: PW]} +
                        {prev[(2*k+1)*PW + PW - 1], prev[(2*k+1)*PW +: PW]};
                end
            end

            // Level register; frozen together with the rest of the pipe on stall.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    data  <= '0;
                    valid <= 1'b0;
                    tag   <= '0;
                end else if (i_en) begin
                    data  <= sum_d;
                    valid <= g_lvl[l-1].valid;
                    tag   <= g_lvl[l-1].tag;
                end
            end
        end
    end

    assign o_data  = g_lvl[LEVELS].data;
    assign o_valid = g_lvl[LEVELS].valid;
    assign o_tag   = g_lvl[LEVELS].tag;

endmodule

// File: rtl/vec_dot_pipe.sv
// Pipelined signed/unsigned dot product with multi-beat accumulation.
// Stages: S0 multiply, log2(VEC_SIZE) tree levels, ACC. One global stall enable.
module vec_dot_pipe
    import vec_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int unsigned VEC_SIZE   = DEF_VEC_SIZE,
    parameter int unsigned MAX_CHUNKS = DEF_MAX_CHUNKS,
    parameter int unsigned RES_WIDTH  = res_width(BIT_WIDTH, VEC_SIZE, MAX_CHUNKS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [BIT_WIDTH*VEC_SIZE-1:0] i_a,
    input  logic [BIT_WIDTH*VEC_SIZE-1:0] i_b,
    input  logic                          i_signed,
    input  logic                          i_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [RES_WIDTH-1:0]          o_product,
    output logic                          o_overflow
);

    // Products carry one extra bit so the tree can treat both modes as signed.
    localparam int unsigned PW      = 2 * BIT_WIDTH + 1;
    localparam int unsigned LEVELS  = $clog2(VEC_SIZE);
    localparam int unsigned TREE_W  = PW + LEVELS;
    localparam int unsigned CNT_W   = $clog2(MAX_CHUNKS) + 1;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned TAG_FST = 2;
    localparam int unsigned TAG_LST = 1;
    localparam int unsigned TAG_OVF = 0;

    logic en;

    // Sequence tracking at the input.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             seq_signed_q, seq_signed_d;
    logic             first_beat, beat_signed, beat_ovf, accept;

    // S0 products.
    logic [VEC_SIZE*PW-1:0] prod_ext;
    logic                   s0_valid_q;
    logic [VEC_SIZE*PW-1:0] s0_data_q;
    logic [TAG_W-1:0]       s0_tag_q;

    // Tree output.
    logic              tree_valid;
    logic [TREE_W-1:0] tree_data;
    logic [TAG_W-1:0]  tree_tag;

    // Accumulator and output registers.
    logic signed [TREE_W-1:0]    tree_s;
    logic [RES_WIDTH-1:0]        tree_ext, acc_sum;
    logic [RES_WIDTH-1:0]        acc_q, acc_d;
    logic [RES_WIDTH-1:0]        prod_q, prod_d;
    logic                        out_ovf_q, out_ovf_d;
    logic                        out_valid_q, out_valid_d;

    // Whole pipe stalls only when a result is held against a busy consumer.
    assign en      = !(out_valid_q && !i_ready);
    assign o_ready = en;
    assign accept  = i_valid && en;

    // Beat classification and sequence bookkeeping; counter saturates at MAX_CHUNKS.
    always_comb begin
        first_beat   = (cnt_q == '0);
        beat_signed  = first_beat ? i_signed : seq_signed_q;
        beat_ovf     = ovf_q || (cnt_q == CNT_W'(MAX_CHUNKS));
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        seq_signed_d = seq_signed_q;
        if (accept) begin
            if (i_last) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else begin
                cnt_d        = (cnt_q == CNT_W'(MAX_CHUNKS)) ? cnt_q : cnt_q + 1'b1;
                ovf_d        = beat_ovf;
                seq_signed_d = beat_signed;
            end
        end
    end

    // Sequence state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            seq_signed_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            seq_signed_q <= seq_signed_d;
        end
    end

    // Per-element multiply, extended to PW bits according to the sequence mode.
    always_comb begin
        logic [BIT_WIDTH-1:0]   ea, eb;
        logic [2*BIT_WIDTH-1:0] p_s, p_u;
        prod_ext = '0;
        for (int k = 0; k < int'(VEC_SIZE); k++) begin
            ea  = i_a[k*BIT_WIDTH +: BIT_WIDTH];
            eb  = i_b[k*BIT_WIDTH +: BIT_WIDTH];
            // Low 2*BIT_WIDTH bits of the sign-extended product are the exact signed product.
            p_s = {{BIT_WIDTH{ea[BIT_WIDTH-1]}}, ea} * {{BIT_WIDTH{eb[BIT_WIDTH-1]}}, eb};
            p_u = {{BIT_WIDTH{1'b0}}, ea} * {{BIT_WIDTH{1'b0}}, eb};
            prod_ext[k*PW +: PW] = beat_signed ? {p_s[2*BIT_WIDTH-1], p_s} : {1'b0, p_u};
        end
    end

    // S0 register: products plus the beat's first/last/overflow tag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            s0_tag_q   <= '0;
        end else if (en) begin
            s0_valid_q <= i_valid;
            s0_data_q  <= prod_ext;
            s0_tag_q   <= {first_beat, i_last, beat_ovf};
        end
    end

    adder_tree_pipe #(
        .N         (VEC_SIZE),
        .IN_WIDTH  (PW),
        .TAG_WIDTH (TAG_W)
    ) u_tree (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (en),
        .i_valid (s0_valid_q),
        .i_data  (s0_data_q),
        .i_tag   (s0_tag_q),
        .o_valid (tree_valid),
        .o_data  (tree_data),
        .o_tag   (tree_tag)
    );

    // Accumulate tree output; a last beat moves the total to the output register.
    always_comb begin
        tree_s      = signed'(tree_data);
        tree_ext    = RES_WIDTH'(tree_s);
        acc_sum     = tree_tag[TAG_FST] ? tree_ext : acc_q + tree_ext;
        acc_d       = acc_q;
        prod_d      = prod_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        if (en) begin
            // en with a valid output means it was just taken.
            out_valid_d = 1'b0;
            if (tree_valid) begin
                if (tree_tag[TAG_LST]) begin
                    prod_d      = acc_sum;
                    out_ovf_d   = tree_tag[TAG_OVF];
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d = acc_sum;
                end
            end
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q       <= '0;
            prod_q      <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o_valid    = out_valid_q;
    assign o_product  = prod_q;
    assign o_overflow = out_ovf_q;

endmodule

// File: tb/tb_vec_dot_pipe.sv
// Scoreboard bench for vec_dot_pipe: driver pushes expected results from an
// arithmetic dot-product model, a negedge monitor pops and compares.
module tb_vec_dot_pipe;
    import vec_pkg::*;

    localparam int BW  = 4;
    localparam int VS  = 64;
    localparam int MC  = 16;
    localparam int RW  = int'(res_width(BW, VS, MC));
    localparam int LAT = $clog2(VS) + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_valid, o_ready, i_signed, i_last, o_valid, i_ready, o_overflow;
    logic [BW*VS-1:0]  i_a, i_b;
    logic [RW-1:0]     o_product;

    vec_dot_pipe #(
        .BIT_WIDTH  (BW),
        .VEC_SIZE   (VS),
        .MAX_CHUNKS (MC)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_signed   (i_signed),
        .i_last     (i_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_product  (o_product),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] prod;
        logic          ovf;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     m_sgn = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (rdy_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ($urandom_range(0, 3) != 0);
            default: i_ready = 1'b0;
        endcase
    end

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [BW*VS-1:0] fill(int v);
        logic [BW*VS-1:0] r;
        for (int k = 0; k < VS; k++) r[k*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [BW*VS-1:0] rand_vec();
        logic [BW*VS-1:0] r;
        for (int k = 0; k < VS; k++) r[k*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    // Plain integer dot product of the two vectors under the given mode.
    function automatic longint dot(logic [BW*VS-1:0] a, logic [BW*VS-1:0] b, bit sgn);
        longint s = 0;
        for (int k = 0; k < VS; k++) begin
            int ea = int'(a[k*BW +: BW]);
            int eb = int'(b[k*BW +: BW]);
            if (sgn && ea >= (1 << (BW - 1))) ea -= (1 << BW);
            if (sgn && eb >= (1 << (BW - 1))) eb -= (1 << BW);
            s += longint'(ea * eb);
        end
        return s;
    endfunction

    task automatic send_beat(logic [BW*VS-1:0] a, logic [BW*VS-1:0] b, bit sgn, bit last,
                             bit chk);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        i_a = a; i_b = b; i_signed = sgn; i_last = last; i_valid = 1'b1;
        #1;
        while (!o_ready && waited < 300) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!o_ready) begin
            check("accept_timeout", 0, 1);
            i_valid = 1'b0;
            return;
        end
        if (m_cnt == 0) m_sgn = sgn;
        m_sum += dot(a, b, m_sgn);
        m_cnt++;
        if (last) begin
            e.prod    = m_sum[RW-1:0];
            e.ovf     = (m_cnt > MC);
            e.acc_cyc = cyc;
            e.chk_lat = chk;
            sb_q.push_back(e);
            m_sum = 0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops on each output handshake, checks hold stability while stalled.
    bit            hold = 0, prev_valid = 0, prev_hs = 0;
    logic [RW-1:0] held_prod;
    logic          held_ovf;
    int            appear_cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            hold = 0; prev_valid = 0; prev_hs = 0;
        end else begin
            if (hold) begin
                check("hold_valid", o_valid, 1);
                check("hold_product", o_product, held_prod);
                check("hold_overflow", o_overflow, held_ovf);
            end
            if (o_valid && (!prev_valid || prev_hs)) appear_cyc = cyc;
            prev_valid = o_valid;
            prev_hs    = o_valid && i_ready;
            hold       = o_valid && !i_ready;
            held_prod  = o_product;
            held_ovf   = o_overflow;
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("product", o_product, e.prod);
                    check("overflow", o_overflow, e.ovf);
                    if (e.chk_lat) check("latency", appear_cyc - e.acc_cyc, LAT);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_signed = 1'b0; i_last = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_valid", o_valid, 0);
        check("reset_product", o_product, 0);
        check("reset_overflow", o_overflow, 0);
        check("reset_ready", o_ready, 1);

        // Signed single beat: 64 * (-1 * 2) = -128.
        send_beat(fill(15), fill(2), 1, 1, 1);
        drain();
        // Unsigned single beat: 64 * 225 = 14400.
        send_beat(fill(15), fill(15), 0, 1, 1);
        drain();
        // Four-beat sequence: 4 * 64 * 49 = 12544.
        for (int i = 0; i < 4; i++) send_beat(fill(7), fill(7), 1, i == 3, i == 3);
        drain();

        // Backpressure: three back-to-back single-beat sequences against a 20-cycle stall.
        rdy_mode = 2;
        for (int i = 1; i <= 3; i++) send_beat(fill(i), fill(1), 1, 1, 0);
        repeat (12) @(negedge clk);
        #1;
        check("stall_ready", o_ready, 0);
        check("stall_valid", o_valid, 1);
        repeat (5) @(negedge clk);
        rdy_mode = 0;
        drain();

        // Overflow: 17 beats of ones, then a clean sequence.
        for (int i = 0; i < 17; i++) send_beat(fill(1), fill(1), 0, i == 16, 1);
        send_beat(fill(1), fill(1), 0, 1, 1);
        drain();

        // Random sequences with random mode, gaps and backpressure.
        rdy_mode = 1;
        for (int s = 0; s < 30; s++) begin
            int len = int'($urandom_range(1, 5));
            for (int i = 0; i < len; i++) begin
                send_beat(rand_vec(), rand_vec(), 1'($urandom), i == len - 1, 0);
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        // Asynchronous reset while a result is held and a sequence is half-accepted.
        rdy_mode = 2;
        send_beat(fill(1), fill(1), 1, 1, 0);
        send_beat(fill(2), fill(1), 1, 0, 0);
        send_beat(fill(2), fill(1), 1, 0, 0);
        repeat (12) @(negedge clk);
        #1;
        check("pre_reset_valid", o_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", o_valid, 0);
        check("async_reset_product", o_product, 0);
        check("async_reset_overflow", o_overflow, 0);
        check("async_reset_ready", o_ready, 1);
        sb_q.delete();
        m_sum = 0;
        m_cnt = 0;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_beat(fill(1), fill(1), 0, 1, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
